// File: rtl/mult_pkg.sv
// Shared definitions for the multiplier subsystem.
//   mult_state_t : 2-bit FSM encoding (IDLE/ADD/SHIFT/DONE) reused by multiplier blocks.
//   clog2        : constant function sizing counters.
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ADD   = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } mult_state_t;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/serial_mult_ctrl_if.sv
// Operand/product handshake bundle for serial_mult_ctrl.
//   in_valid/in_ready/a/b        : operand channel (valid/ready)
//   out_valid/out_ready/product  : result channel (valid/ready)
//   busy                         : engine occupied
// master = producer/consumer side, slave = multiplier side.
interface serial_mult_ctrl_if #(
  parameter int unsigned WIDTH = 8
);
  logic                   in_valid;
  logic                   in_ready;
  logic [WIDTH-1:0]       a;
  logic [WIDTH-1:0]       b;
  logic                   out_valid;
  logic                   out_ready;
  logic [2*WIDTH-1:0]     product;
  logic                   busy;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, product, busy
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, product, busy
  );
endinterface

// File: rtl/fullAdder.sv
// Single-bit full adder cell, time-shared by the serial multiplier.
//   x, y, cin : addend bits and carry in
//   sum, c_out: sum bit and carry out
module fullAdder (
  input  logic x,
  input  logic y,
  input  logic cin,
  output logic sum,
  output logic c_out
);
  assign sum   = x ^ y ^ cin;
  assign c_out = (x & y) | (cin & (x ^ y));
endmodule

// File: rtl/serial_mult_ctrl.sv
// Bit-serial shift-add unsigned multiplier using one shared full adder.
// Each multiplier bit costs one ADD pass (WIDTH cycles, one adder bit per
// cycle) followed by one SHIFT cycle; one operation in flight at a time.
//   clk, rst : clock, synchronous active-high reset
//   bus      : serial_mult_ctrl_if.slave (a/b valid/ready in, product valid/ready out, busy)
// Optional build macro SERIAL_MULT_SKIP_ZERO_EN: zero multiplier bits skip
// their ADD pass (1 cycle instead of WIDTH+1). Products are identical.
module serial_mult_ctrl
  import mult_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  serial_mult_ctrl_if.slave bus
);

  localparam int unsigned   CW   = (clog2(WIDTH) < 1) ? 1 : clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  mult_state_t          state, state_next;
  logic [2*WIDTH-1:0]   p;
  logic [2*WIDTH-1:0]   p_shifted;
  logic [2*WIDTH-1:0]   product_q;
  logic [WIDTH-1:0]     mcand_sr;
  logic [CW-1:0]        iter;
  logic [CW-1:0]        bitcnt;
  logic                 carry;
  logic                 mbit;
  logic                 fa_y;
  logic                 fa_sum;
  logic                 fa_cout;
  logic                 accept;

  assign accept    = (state == IDLE) && bus.in_valid;
  // The lower half of P is untouched during ADD, so its LSB is the current
  // multiplier bit; after SHIFT it holds the next one. No separate flop needed.
  assign mbit      = p[0];
  assign fa_y      = mcand_sr[0] & mbit;
  assign p_shifted = {carry, p[2*WIDTH-1:1]};

  fullAdder u_fa (
    .x     (p[WIDTH]),
    .y     (fa_y),
    .cin   (carry),
    .sum   (fa_sum),
    .c_out (fa_cout)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (accept) begin
`ifdef SERIAL_MULT_SKIP_ZERO_EN
          state_next = bus.b[0] ? ADD : SHIFT;
`else
          state_next = ADD;
`endif
        end
      end
      ADD: begin
        if (bitcnt == LAST) state_next = SHIFT;
      end
      SHIFT: begin
        if (iter == LAST) begin
          state_next = DONE;
        end else begin
`ifdef SERIAL_MULT_SKIP_ZERO_EN
          // p[1] becomes the multiplier bit once this shift lands.
          state_next = p[1] ? ADD : SHIFT;
`else
          state_next = ADD;
`endif
        end
      end
      DONE: begin
        if (bus.out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      p         <= '0;
      mcand_sr  <= '0;
      iter      <= '0;
      bitcnt    <= '0;
      carry     <= 1'b0;
      product_q <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            mcand_sr <= bus.a;
            p        <= {{WIDTH{1'b0}}, bus.b};
            iter     <= '0;
            bitcnt   <= '0;
            carry    <= 1'b0;
          end
        end
        ADD: begin
          // Upper half and multiplicand rotate once per adder bit; after WIDTH
          // cycles both are back in place with the upper half summed.
          p[2*WIDTH-1:WIDTH] <= {fa_sum, p[2*WIDTH-1:WIDTH+1]};
          mcand_sr           <= {mcand_sr[0], mcand_sr[WIDTH-1:1]};
          carry              <= fa_cout;
          bitcnt             <= bitcnt + 1'b1;
        end
        SHIFT: begin
          p      <= p_shifted;
          carry  <= 1'b0;
          bitcnt <= '0;
          if (iter == LAST) product_q <= p_shifted;
          else              iter      <= iter + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.busy      = (state != IDLE);
  assign bus.product   = product_q;

endmodule

// File: tb/tb_serial_mult_ctrl.sv
// Self-checking bench for serial_mult_ctrl: a W=8 and a W=4 instance run
// against a latency/product model, plus hand-computed directed cases on W=8.
module tb_serial_mult_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  serial_mult_ctrl_if #(.WIDTH(8)) if8 ();
  serial_mult_ctrl_if #(.WIDTH(4)) if4 ();

  serial_mult_ctrl #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(if8.slave));
  serial_mult_ctrl #(.WIDTH(4)) dut4 (.clk(clk), .rst(rst), .bus(if4.slave));

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input int inst,
                     input longint unsigned act, input longint unsigned exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s[w%0d] actual=%0d expected=%0d t=%0t",
               nm, (inst == 0) ? 8 : 4, act, exp, $time);
    end
  endtask

  // Latency rule: fixed W*(W+1), or per-bit cost when zero bits are skipped.
  function automatic int unsigned lat_of(input int unsigned w, input longint unsigned bv);
    int unsigned s;
    s = 0;
    for (int unsigned i = 0; i < w; i++) s += (((bv >> i) & 64'd1) != 0) ? w + 1 : 1;
`ifdef SERIAL_MULT_SKIP_ZERO_EN
    return s;
`else
    return w * (w + 1);
`endif
  endfunction

  // Hand-computed W=8 latency: skip-build value given, otherwise 72.
  function automatic int unsigned lit_lat(input int unsigned sk);
`ifdef SERIAL_MULT_SKIP_ZERO_EN
    return sk;
`else
    return 72 + 0 * sk;
`endif
  endfunction

  function automatic longint unsigned rop(input int unsigned w);
    longint unsigned m;
    int unsigned r;
    m = (64'd1 << w) - 64'd1;
    r = $urandom_range(0, 7);
    if (r == 0) return 64'd0;
    if (r == 1) return m;
    return {32'd0, $urandom} & m;
  endfunction

  // Sampled interface views, index 0 = W8, 1 = W4.
  int unsigned     wid [2] = '{8, 4};
  logic            iv [2];
  logic            ordy [2];
  longint unsigned ia [2];
  longint unsigned ib [2];
  logic            d_ir [2];
  logic            d_ov [2];
  logic            d_busy [2];
  longint unsigned d_prod [2];

  always_comb begin
    iv[0]     = if8.in_valid;   iv[1]     = if4.in_valid;
    ordy[0]   = if8.out_ready;  ordy[1]   = if4.out_ready;
    ia[0]     = 64'(if8.a);     ia[1]     = 64'(if4.a);
    ib[0]     = 64'(if8.b);     ib[1]     = 64'(if4.b);
    d_ir[0]   = if8.in_ready;   d_ir[1]   = if4.in_ready;
    d_ov[0]   = if8.out_valid;  d_ov[1]   = if4.out_valid;
    d_busy[0] = if8.busy;       d_busy[1] = if4.busy;
    d_prod[0] = 64'(if8.product); d_prod[1] = 64'(if4.product);
  end

  // Model: idle / running for a computed number of edges / holding a result.
  typedef enum {M_IDLE, M_RUN, M_DONE} mphase_t;
  mphase_t         ph [2];
  longint unsigned expv [2];
  longint unsigned held [2];
  int unsigned     cnt [2];
  int unsigned     lat [2];
  int unsigned     ndone [2] = '{0, 0};
  bit              armed = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      armed <= 1'b1;
      for (int i = 0; i < 2; i++) begin
        ph[i]   <= M_IDLE;
        held[i] <= 64'd0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        case (ph[i])
          M_IDLE: if (iv[i]) begin
            expv[i] <= ia[i] * ib[i];
            lat[i]  <= lat_of(wid[i], ib[i]);
            cnt[i]  <= 0;
            ph[i]   <= M_RUN;
          end
          M_RUN: begin
            cnt[i] <= cnt[i] + 1;
            if (cnt[i] + 1 == lat[i]) begin
              ph[i]   <= M_DONE;
              held[i] <= expv[i];
            end
          end
          default: if (ordy[i]) begin
            ph[i]    <= M_IDLE;
            ndone[i] <= ndone[i] + 1;
          end
        endcase
      end
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      for (int i = 0; i < 2; i++) begin
        chk("in_ready",  i, d_ir[i],   ph[i] == M_IDLE);
        chk("busy",      i, d_busy[i], ph[i] != M_IDLE);
        chk("out_valid", i, d_ov[i],   ph[i] == M_DONE);
        chk("product",   i, d_prod[i], held[i]);
      end
    end
  end

  // Directed W=8 operation; starts and ends just after a falling edge.
  task automatic run_op(input logic [7:0] av, input logic [7:0] bv,
                        input longint unsigned expp, input int unsigned explat,
                        input int unsigned hold, input string nm);
    int unsigned n;
    if8.a = av; if8.b = bv; if8.in_valid = 1'b1;
    if8.out_ready = (hold == 0);
    @(negedge clk);
    if8.in_valid = 1'b0;
    n = 0;
    while (!if8.out_valid && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_latency"}, 0, n, explat);
    chk({nm, "_product"}, 0, 64'(if8.product), expp);
    for (int unsigned k = 0; k < hold; k++) begin
      if8.in_valid = 1'b1; if8.a = 8'd9; if8.b = 8'd9;
      @(negedge clk);
      chk({nm, "_hold_product"}, 0, 64'(if8.product), expp);
      chk({nm, "_hold_valid"},   0, if8.out_valid, 1);
      chk({nm, "_hold_ready"},   0, if8.in_ready, 0);
    end
    if8.in_valid = 1'b0;
    if8.out_ready = 1'b1;
    @(negedge clk);
    if8.out_ready = 1'b0;
    chk({nm, "_back_idle"}, 0, if8.in_ready, 1);
    chk({nm, "_valid_drop"}, 0, if8.out_valid, 0);
  endtask

  initial begin
    int unsigned base0, base1, c;
    if8.in_valid = 1'b0; if8.a = '0; if8.b = '0; if8.out_ready = 1'b0;
    if4.in_valid = 1'b0; if4.a = '0; if4.b = '0; if4.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("reset_in_ready",  0, if8.in_ready, 1);
    chk("reset_out_valid", 0, if8.out_valid, 0);
    chk("reset_busy",      0, if8.busy, 0);
    chk("reset_product",   0, 64'(if8.product), 0);

    run_op(8'd3,   8'd5,   15,    lit_lat(24), 0,  "mul3x5");
    run_op(8'd255, 8'd255, 65025, lit_lat(72), 0,  "all_ones");
    run_op(8'd0,   8'd200, 0,     lit_lat(32), 0,  "a_zero");
    run_op(8'd13,  8'd11,  143,   lit_lat(32), 10, "backpressure");

    // Reset in the middle of an operation.
    if8.a = 8'd200; if8.b = 8'd77; if8.in_valid = 1'b1;
    @(negedge clk);
    if8.in_valid = 1'b0;
    repeat (29) @(negedge clk);
    chk("mid_op_busy", 0, if8.busy, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_out_valid", 0, if8.out_valid, 0);
    chk("mid_rst_in_ready",  0, if8.in_ready, 1);
    chk("mid_rst_product",   0, 64'(if8.product), 0);
    chk("mid_rst_busy",      0, if8.busy, 0);

    run_op(8'd7,   8'd9,   63,  lit_lat(24), 0, "after_rst");
    run_op(8'd100, 8'd1,   100, lit_lat(16), 0, "b_one");
    run_op(8'd55,  8'd0,   0,   lit_lat(8),  0, "b_zero");
    run_op(8'd2,   8'd255, 510, lit_lat(72), 0, "b_ones");

    // Random traffic on both widths with gaps on both channels.
    base0 = ndone[0];
    base1 = ndone[1];
    c = 0;
    while (((ndone[0] - base0) < 300 || (ndone[1] - base1) < 1000) && c < 60000) begin
      if8.in_valid  = ($urandom_range(0, 3) != 0);
      if8.a         = 8'(rop(8));
      if8.b         = 8'(rop(8));
      if8.out_ready = ($urandom_range(0, 2) != 0);
      if4.in_valid  = ($urandom_range(0, 3) != 0);
      if4.a         = 4'(rop(4));
      if4.b         = 4'(rop(4));
      if4.out_ready = ($urandom_range(0, 2) != 0);
      @(negedge clk);
      c++;
    end
    chk("random_ops_w8", 0, 64'((ndone[0] - base0) >= 300), 1);
    chk("random_ops_w4", 1, 64'((ndone[1] - base1) >= 1000), 1);

    if8.in_valid = 1'b0; if8.out_ready = 1'b0;
    if4.in_valid = 1'b0; if4.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
